axi_lite_cmd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single AXI-Lite master command port (valid_in / wr_in / address / data / strobe) among NUM_REQ local requesters, such as GPIO and control clients. It takes one command at a time, drives the master's user-side inputs, and detects completion by snooping the master's B/R channel handshakes and timeout flags. It then returns the response to the granted requester and enforces a gap so the master is back in idle before the next issue.

---
 rtl/axi_lite_cmd_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_lite_cmd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter
// Round-robin arbiter that shares one AXI-Lite master command port among
// NUM_REQ local requesters. One command is in flight at a time. Completion
// is detected by snooping the master's B/R handshakes and timeout flags,
// with a local watchdog as a backstop. After each response the arbiter
// idles for GAP_CYC cycles so the master is back in idle before the next issue.
module axi_lite_cmd_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WATCHDOG = 64,
    parameter int GAP_CYC  = 2
) (
    input  logic                   m_axi_aclock,
    input  logic                   m_axi_areset,

    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [4*NUM_REQ-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]     req_ready,

    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [1:0]             rsp_resp,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_timeout,

    output logic                   mst_valid_in,
    output logic                   mst_wr_in,
    output logic [31:0]            mst_write_addr,
    output logic [31:0]            mst_read_addr,
    output logic [31:0]            mst_write_data,
    output logic [3:0]             mst_write_strb,

    input  logic                   snp_bvalid,
    input  logic                   snp_bready,
    input  logic [1:0]             snp_bresp,
    input  logic                   snp_rvalid,
    input  logic                   snp_rready,
    input  logic [1:0]             snp_rresp,
    input  logic [31:0]            snp_rdata,
    input  logic                   mst_wr_timeout,
    input  logic                   mst_rd_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(WATCHDOG + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               cmd_wr_q, cmd_wr_d;
    logic [31:0]        cmd_addr_q, cmd_addr_d;
    logic [31:0]        cmd_wdata_q, cmd_wdata_d;
    logic [3:0]         cmd_wstrb_q, cmd_wstrb_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         rsp_resp_q, rsp_resp_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic               any_req;
    logic [IDX_W-1:0]   grant_idx;
    logic               done;
    logic [1:0]         done_resp;
    logic [31:0]        done_rdata;
    logic               done_timeout;

    // Round-robin search: first active requester after the last grant, with wrap.
    always_comb begin
        int cand;
        cand      = 0;
        any_req   = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(last_grant_q) + 1 + i) % NUM_REQ;
            if (!any_req && req_valid[cand]) begin
                any_req   = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    // Completion detection in WAIT: matching-direction handshake beats the
    // master timeout flag, and the watchdog only fires if nothing else did.
    always_comb begin
        done         = 1'b0;
        done_resp    = 2'b00;
        done_rdata   = 32'h0;
        done_timeout = 1'b0;
        if (cmd_wr_q) begin
            if (snp_bvalid && snp_bready) begin
                done      = 1'b1;
                done_resp = snp_bresp;
            end else if (mst_wr_timeout) begin
                done         = 1'b1;
                done_resp    = 2'b10;
                done_timeout = 1'b1;
            end
        end else begin
            if (snp_rvalid && snp_rready) begin
                done       = 1'b1;
                done_resp  = snp_rresp;
                done_rdata = snp_rdata;
            end else if (mst_rd_timeout) begin
                done         = 1'b1;
                done_resp    = 2'b10;
                done_timeout = 1'b1;
            end
        end
        if (!done && (wd_q == WD_W'(WATCHDOG - 1))) begin
            done         = 1'b1;
            done_resp    = 2'b10;
            done_timeout = 1'b1;
        end
    end

    // State register plus all datapath flops; reset abandons any command.
    always_ff @(posedge m_axi_aclock or negedge m_axi_areset) begin
        if (!m_axi_areset) begin
            state_q       <= IDLE;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            req_ready_q   <= '0;
            cmd_wr_q      <= 1'b0;
            cmd_addr_q    <= 32'h0;
            cmd_wdata_q   <= 32'h0;
            cmd_wstrb_q   <= 4'h0;
            wd_q          <= '0;
            gap_q         <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_rdata_q   <= 32'h0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            req_ready_q   <= req_ready_d;
            cmd_wr_q      <= cmd_wr_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_wstrb_q   <= cmd_wstrb_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic for the command sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done) state_d = RESP;
            RESP:    state_d = (GAP_CYC > 0) ? GAP : IDLE;
            GAP:     if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: grant capture, counters and response latching.
    always_comb begin
        last_grant_d  = last_grant_q;
        req_ready_d   = '0;
        cmd_wr_d      = cmd_wr_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        cmd_wstrb_d   = cmd_wstrb_q;
        wd_d          = wd_q;
        gap_d         = gap_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    last_grant_d = grant_idx;
                    req_ready_d  = NUM_REQ'(1) << grant_idx;
                    cmd_wr_d     = req_wr[grant_idx];
                    cmd_addr_d   = req_addr[grant_idx*32 +: 32];
                    cmd_wdata_d  = req_wdata[grant_idx*32 +: 32];
                    cmd_wstrb_d  = req_wstrb[grant_idx*4 +: 4];
                end
            end
            ISSUE: begin
                wd_d = '0;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (done) begin
                    rsp_resp_d    = done_resp;
                    rsp_rdata_d   = done_rdata;
                    rsp_timeout_d = done_timeout;
                end
            end
            RESP: begin
                gap_d = '0;
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
            end
            default: begin
                wd_d = '0;
            end
        endcase
    end

    // Output decode: command fields are only presented while a command is live.
    always_comb begin
        mst_valid_in   = (state_q == ISSUE);
        mst_wr_in      = 1'b0;
        mst_write_addr = 32'h0;
        mst_read_addr  = 32'h0;
        mst_write_data = 32'h0;
        mst_write_strb = 4'h0;
        if ((state_q == ISSUE) || (state_q == WAIT)) begin
            mst_wr_in      = cmd_wr_q;
            mst_write_addr = cmd_addr_q;
            mst_read_addr  = cmd_addr_q;
            mst_write_data = cmd_wdata_q;
            mst_write_strb = cmd_wstrb_q;
        end
        rsp_valid   = (state_q == RESP) ? (NUM_REQ'(1) << last_grant_q) : '0;
        req_ready   = req_ready_q;
        rsp_resp    = rsp_resp_q;
        rsp_rdata   = rsp_rdata_q;
        rsp_timeout = rsp_timeout_q;
    end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Directed testbench for axi_lite_cmd_arbiter.
module tb_axi_lite_cmd_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int WATCHDOG = 64;
   localparam int GAP_CYC  = 2;

   logic                  clock;
   logic                  resetN;
   logic [NUM_REQ-1:0]    reqValid;
   logic [NUM_REQ-1:0]    reqWr;
   logic [32*NUM_REQ-1:0] reqAddr;
   logic [32*NUM_REQ-1:0] reqWdata;
   logic [4*NUM_REQ-1:0]  reqWstrb;
   logic [NUM_REQ-1:0]    reqReady;
   logic [NUM_REQ-1:0]    rspValid;
   logic [1:0]            rspResp;
   logic [31:0]           rspRdata;
   logic                  rspTimeout;
   logic                  mstValidIn;
   logic                  mstWrIn;
   logic [31:0]           mstWriteAddr;
   logic [31:0]           mstReadAddr;
   logic [31:0]           mstWriteData;
   logic [3:0]            mstWriteStrb;
   logic                  snpBvalid, snpBready, snpRvalid, snpRready;
   logic [1:0]            snpBresp, snpRresp;
   logic [31:0]           snpRdata;
   logic                  mstWrTimeout, mstRdTimeout;

   int checkCount;
   int errorCount;
   int validPulses;
   int readyPulses;

   axi_lite_cmd_arbiter #(
      .NUM_REQ(NUM_REQ),
      .WATCHDOG(WATCHDOG),
      .GAP_CYC(GAP_CYC)
   ) dut (
      .m_axi_aclock(clock),
      .m_axi_areset(resetN),
      .req_valid(reqValid),
      .req_wr(reqWr),
      .req_addr(reqAddr),
      .req_wdata(reqWdata),
      .req_wstrb(reqWstrb),
      .req_ready(reqReady),
      .rsp_valid(rspValid),
      .rsp_resp(rspResp),
      .rsp_rdata(rspRdata),
      .rsp_timeout(rspTimeout),
      .mst_valid_in(mstValidIn),
      .mst_wr_in(mstWrIn),
      .mst_write_addr(mstWriteAddr),
      .mst_read_addr(mstReadAddr),
      .mst_write_data(mstWriteData),
      .mst_write_strb(mstWriteStrb),
      .snp_bvalid(snpBvalid),
      .snp_bready(snpBready),
      .snp_bresp(snpBresp),
      .snp_rvalid(snpRvalid),
      .snp_rready(snpRready),
      .snp_rresp(snpRresp),
      .snp_rdata(snpRdata),
      .mst_wr_timeout(mstWrTimeout),
      .mst_rd_timeout(mstRdTimeout)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Count strobe pulses on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (mstValidIn) validPulses++;
      if (reqReady != '0) readyPulses++;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one requester's request and command fields.
   task automatic applyStimulus(input int idx, input logic valid, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      reqValid[idx]          = valid;
      reqWr[idx]             = wr;
      reqAddr[idx*32 +: 32]  = addr;
      reqWdata[idx*32 +: 32] = wdata;
      reqWstrb[idx*4 +: 4]   = wstrb;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Step until a response pulse appears or the budget runs out.
   task automatic waitRsp(input int bound, output int cycles);
      cycles = 0;
      while (rspValid == '0 && cycles < bound) begin
         step();
         cycles++;
      end
   endtask

   task automatic clearSnoop();
      snpBvalid = 0; snpBready = 0; snpBresp = 0;
      snpRvalid = 0; snpRready = 0; snpRresp = 0; snpRdata = 0;
      mstWrTimeout = 0; mstRdTimeout = 0;
   endtask

   initial begin
      int cycles;
      int startValid;
      int startReady;
      checkCount = 0;
      errorCount = 0;
      validPulses = 0;
      readyPulses = 0;
      resetN   = 1'b0;
      reqValid = '0; reqWr = '0; reqAddr = '0; reqWdata = '0; reqWstrb = '0;
      clearSnoop();

      // Reset state
      step(); step();
      checkOutput("rst_req_ready", 32'(reqReady), 32'h0);
      checkOutput("rst_rsp_valid", 32'(rspValid), 32'h0);
      checkOutput("rst_mst_valid", 32'(mstValidIn), 32'h0);
      checkOutput("rst_rsp_resp", 32'(rspResp), 32'h0);
      checkOutput("rst_waddr", mstWriteAddr, 32'h0);
      resetN = 1'b1;
      step();

      // Single write by requester 1, B handshake three cycles after issue
      $display("[TB] write by req1");
      startValid = validPulses;
      startReady = readyPulses;
      applyStimulus(1, 1, 1, 32'h10, 32'hA5A5_0001, 4'hF);
      step();
      checkOutput("wr_req_ready", 32'(reqReady), 32'h2);
      checkOutput("wr_mst_valid", 32'(mstValidIn), 32'h1);
      checkOutput("wr_mst_wr", 32'(mstWrIn), 32'h1);
      checkOutput("wr_waddr", mstWriteAddr, 32'h10);
      checkOutput("wr_raddr", mstReadAddr, 32'h10);
      checkOutput("wr_wdata", mstWriteData, 32'hA5A5_0001);
      checkOutput("wr_wstrb", 32'(mstWriteStrb), 32'hF);
      applyStimulus(1, 0, 0, 0, 0, 0);
      step();
      checkOutput("wr_wait_valid", 32'(mstValidIn), 32'h0);
      checkOutput("wr_wait_wdata", mstWriteData, 32'hA5A5_0001);
      step(); step();
      checkOutput("wr_no_early_rsp", 32'(rspValid), 32'h0);
      snpBvalid = 1; snpBready = 1; snpBresp = 2'b00;
      step();
      clearSnoop();
      checkOutput("wr_rsp_valid", 32'(rspValid), 32'h2);
      checkOutput("wr_rsp_resp", 32'(rspResp), 32'h0);
      checkOutput("wr_rsp_timeout", 32'(rspTimeout), 32'h0);
      step();
      checkOutput("wr_rsp_pulse", 32'(rspValid), 32'h0);
      checkOutput("wr_valid_pulses", 32'(validPulses - startValid), 32'h1);
      checkOutput("wr_ready_pulses", 32'(readyPulses - startReady), 32'h1);
      step(); step();

      // Read by requester 0; a write-channel handshake must be ignored
      $display("[TB] read by req0");
      applyStimulus(0, 1, 0, 32'h04, 32'h0, 4'h0);
      step();
      checkOutput("rd_req_ready", 32'(reqReady), 32'h1);
      checkOutput("rd_mst_wr", 32'(mstWrIn), 32'h0);
      checkOutput("rd_raddr", mstReadAddr, 32'h04);
      applyStimulus(0, 0, 0, 0, 0, 0);
      step();
      snpBvalid = 1; snpBready = 1; snpBresp = 2'b11;
      step();
      clearSnoop();
      checkOutput("rd_ignore_b", 32'(rspValid), 32'h0);
      checkOutput("rd_mst_wr_wait", 32'(mstWrIn), 32'h0);
      snpRvalid = 1; snpRready = 1; snpRresp = 2'b00; snpRdata = 32'hDEAD_BEEF;
      step();
      clearSnoop();
      checkOutput("rd_rsp_valid", 32'(rspValid), 32'h1);
      checkOutput("rd_rsp_rdata", rspRdata, 32'hDEAD_BEEF);
      checkOutput("rd_rsp_resp", 32'(rspResp), 32'h0);
      step(); step(); step();

      // Master write timeout by requester 2
      $display("[TB] master write timeout");
      applyStimulus(2, 1, 1, 32'h20, 32'h1234, 4'h3);
      step();
      checkOutput("wto_req_ready", 32'(reqReady), 32'h4);
      applyStimulus(2, 0, 0, 0, 0, 0);
      step();
      mstWrTimeout = 1;
      step();
      clearSnoop();
      checkOutput("wto_rsp_valid", 32'(rspValid), 32'h4);
      checkOutput("wto_rsp_resp", 32'(rspResp), 32'h2);
      checkOutput("wto_rsp_timeout", 32'(rspTimeout), 32'h1);
      checkOutput("wto_rsp_rdata", rspRdata, 32'h0);
      step(); step(); step();

      // Watchdog on a read by requester 3 with a silent slave
      $display("[TB] watchdog");
      applyStimulus(3, 1, 0, 32'h30, 32'h0, 4'h0);
      step();
      checkOutput("wd_req_ready", 32'(reqReady), 32'h8);
      applyStimulus(3, 0, 0, 0, 0, 0);
      waitRsp(200, cycles);
      checkOutput("wd_latency", 32'(cycles), 32'(WATCHDOG + 1));
      checkOutput("wd_rsp_valid", 32'(rspValid), 32'h8);
      checkOutput("wd_rsp_resp", 32'(rspResp), 32'h2);
      checkOutput("wd_rsp_timeout", 32'(rspTimeout), 32'h1);
      step(); step(); step();

      // Reset in the middle of WAIT
      $display("[TB] reset mid-WAIT");
      applyStimulus(2, 1, 1, 32'h44, 32'h5555_AAAA, 4'hC);
      step();
      applyStimulus(2, 0, 0, 0, 0, 0);
      step();
      checkOutput("mid_wait_addr", mstWriteAddr, 32'h44);
      resetN = 1'b0;
      #1;
      checkOutput("mid_rst_waddr", mstWriteAddr, 32'h0);
      checkOutput("mid_rst_mst_wr", 32'(mstWrIn), 32'h0);
      checkOutput("mid_rst_resp", 32'(rspResp), 32'h0);
      checkOutput("mid_rst_timeout", 32'(rspTimeout), 32'h0);
      snpBvalid = 1; snpBready = 1;
      step(); step();
      clearSnoop();
      checkOutput("mid_rst_no_rsp", 32'(rspValid), 32'h0);
      resetN = 1'b1;
      step();

      // Requester 0 wins after reset; handshake beats a same-cycle read timeout
      $display("[TB] post-reset priority and handshake vs timeout");
      applyStimulus(3, 1, 0, 32'h33, 32'h0, 4'h0);
      applyStimulus(0, 1, 0, 32'h08, 32'h0, 4'h0);
      step();
      checkOutput("prio_req_ready", 32'(reqReady), 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(3, 0, 0, 0, 0, 0);
      step();
      snpRvalid = 1; snpRready = 1; snpRresp = 2'b01; snpRdata = 32'h1234_5678;
      mstRdTimeout = 1;
      step();
      clearSnoop();
      checkOutput("sim_rsp_valid", 32'(rspValid), 32'h1);
      checkOutput("sim_rsp_resp", 32'(rspResp), 32'h1);
      checkOutput("sim_rsp_timeout", 32'(rspTimeout), 32'h0);
      checkOutput("sim_rsp_rdata", rspRdata, 32'h1234_5678);
      step(); step(); step();

      // Fairness: all requesters active from reset, slave answers immediately
      $display("[TB] round-robin fairness");
      resetN = 1'b0;
      step();
      for (int r = 0; r < NUM_REQ; r++) applyStimulus(r, 1, 1, 32'(r * 16), 32'(r), 4'hF);
      snpBvalid = 1; snpBready = 1; snpBresp = 2'b00;
      resetN = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int n;
         n = 0;
         while (reqReady == '0 && n < 50) begin
            step();
            n++;
         end
         if (k > 0) checkOutput($sformatf("rr_gap_%0d", k), 32'(n), 32'(GAP_CYC + 2));
         checkOutput($sformatf("rr_grant_%0d", k), 32'(reqReady), 32'(1 << (k % NUM_REQ)));
         checkOutput($sformatf("rr_onehot_%0d", k), 32'($countones(reqReady)), 32'h1);
         waitRsp(50, n);
         checkOutput($sformatf("rr_rsp_%0d", k), 32'(rspValid), 32'(1 << (k % NUM_REQ)));
      end
      reqValid = '0;
      clearSnoop();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
